// File: rtl/ofs_fim_axis_pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ofs_fim_axis_pipe_pkg                                         |
// | Purpose  : Shared types and helpers for the flushable AXI-S pipeline.    |
// |            pipe_mode_e   - per-stage register style                      |
// |            flush_state_e - sink-side flush FSM states                    |
// |            occ_width()   - width of the beat/packet occupancy counters   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package ofs_fim_axis_pipe_pkg;

  typedef enum logic [1:0] {
    PIPE_SKID   = 2'd0,
    PIPE_SIMPLE = 2'd1,
    PIPE_BUBBLE = 2'd2,
    PIPE_BYPASS = 2'd3
  } pipe_mode_e;

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_DROP = 1'b1
  } flush_state_e;

  // A skid stage holds up to two beats, so the count spans 0..2*depth.
  function automatic int occ_width(input int depth);
    return (depth < 1) ? 1 : $clog2(2 * depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ofs_fim_axis_pipe_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ofs_fim_axis_pipe_stage                                       |
// | Purpose  : One valid/ready register stage over a packed payload bus.     |
// |            MODE selects skid (2 entries, ready from a flop), simple      |
// |            (ready = !valid | m_ready) or bubble (ready = !valid).        |
// | Ports    : clk, rst (async, high), clr (sync clear of held beats),       |
// |            s_valid/s_ready/s_data upstream, m_valid/m_ready/m_data       |
// |            downstream.                                                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ofs_fim_axis_pipe_stage
  import ofs_fim_axis_pipe_pkg::*;
#(
  parameter pipe_mode_e MODE = PIPE_SKID,
  parameter int         W    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);

  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] main_data_q, main_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         s_acc;
  logic         main_free;

  always_comb begin
    case (MODE)
      PIPE_SKID:   s_ready = !skid_valid_q;
      PIPE_BUBBLE: s_ready = !main_valid_q;
      default:     s_ready = !main_valid_q || m_ready;
    endcase
    s_acc        = s_valid && s_ready;
    main_free    = !main_valid_q || m_ready;
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (main_free) begin
      // A parked skid beat is older than anything on the input; while it
      // is parked s_ready is low, so no input beat can be lost here.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = s_acc;
        if (s_acc) main_data_d = s_data;
      end
    end else if (s_acc) begin
      // Only reachable in skid mode: output stalled, take the beat aside.
      skid_valid_d = 1'b1;
      skid_data_d  = s_data;
    end
    if (clr) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    main_data_q <= main_data_d;
    skid_data_q <= skid_data_d;
  end

  assign m_valid = main_valid_q;
  assign m_data  = main_data_q;

endmodule
`default_nettype wire

// File: rtl/ofs_fim_axis_pipeline_flush.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ofs_fim_axis_pipeline_flush                                   |
// | Purpose  : PL_DEPTH-stage AXI-S register pipeline for TLP streams with   |
// |            in-flight beat/packet accounting and a packet-safe flush that |
// |            empties the pipe and drops the rest of the open sink packet.  |
// | Ports    : clk, rst (async, high); s_* sink, m_* source AXI-S;           |
// |            flush (1-cycle request); occ/pkt_cnt in-flight beats/tlasts;  |
// |            idle, dropping status; flush_trunc pulse when a flush cut a   |
// |            packet mid-way on the source; drop_cnt saturating drop count. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ofs_fim_axis_pipeline_flush
  import ofs_fim_axis_pipe_pkg::*;
#(
  parameter  int MODE           = 0,
  parameter  int TREADY_RST_VAL = 0,
  parameter  int TDATA_WIDTH    = 512,
  parameter  int TUSER_WIDTH    = 10,
  parameter  int PL_DEPTH       = 2,
  parameter  int CNT_W          = 16,
  localparam int OCC_W          = occ_width(PL_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic [TDATA_WIDTH-1:0]   s_tdata,
  input  logic [TDATA_WIDTH/8-1:0] s_tkeep,
  input  logic                     s_tlast,
  input  logic [TUSER_WIDTH-1:0]   s_tuser,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [TDATA_WIDTH-1:0]   m_tdata,
  output logic [TDATA_WIDTH/8-1:0] m_tkeep,
  output logic                     m_tlast,
  output logic [TUSER_WIDTH-1:0]   m_tuser,
  input  logic                     flush,
  output logic [OCC_W-1:0]         occ,
  output logic [OCC_W-1:0]         pkt_cnt,
  output logic                     idle,
  output logic                     dropping,
  output logic                     flush_trunc,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int  KEEP_W = TDATA_WIDTH / 8;
  localparam int  PW     = TDATA_WIDTH + KEEP_W + 1 + TUSER_WIDTH;
  localparam int  IW     = OCC_W + 1;
  localparam bit  BYPASS = (PL_DEPTH == 0) || (MODE == 3);
  localparam logic RST_RDY = TREADY_RST_VAL[0];

  if (BYPASS) begin : g_bypass
    assign s_tready    = rst ? RST_RDY : m_tready;
    assign m_tvalid    = s_tvalid && !rst;
    assign m_tdata     = s_tdata;
    assign m_tkeep     = s_tkeep;
    assign m_tlast     = s_tlast;
    assign m_tuser     = s_tuser;
    assign occ         = '0;
    assign pkt_cnt     = '0;
    assign idle        = 1'b1;
    assign dropping    = 1'b0;
    assign flush_trunc = 1'b0;
    assign drop_cnt    = '0;
  end else begin : g_pipe
    logic [PW-1:0]       stg_data  [PL_DEPTH+1];
    logic                stg_valid [PL_DEPTH+1];
    logic                stg_ready [PL_DEPTH+1];

    flush_state_e        state_q, state_d;
    logic [OCC_W-1:0]    occ_q, occ_d;
    logic [OCC_W-1:0]    pkt_cnt_q, pkt_cnt_d;
    logic                in_pkt_q, in_pkt_d;
    logic                out_pkt_q, out_pkt_d;
    logic                flush_trunc_q, flush_trunc_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
    logic [IW-1:0]       drop_inc;
    logic [CNT_W:0]      drop_sum;
    logic                s_acc, m_acc;

    // While dropping, sink beats are swallowed here and never enter the pipe.
    assign stg_valid[0]        = s_tvalid && (state_q == ST_PASS);
    assign stg_data[0]         = {s_tuser, s_tlast, s_tkeep, s_tdata};
    assign stg_ready[PL_DEPTH] = m_tready;

    for (genvar i = 0; i < PL_DEPTH; i++) begin : g_stage
      ofs_fim_axis_pipe_stage #(
        .MODE (pipe_mode_e'(MODE[1:0])),
        .W    (PW)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .clr     (flush && (state_q == ST_PASS)),
        .s_valid (stg_valid[i]),
        .s_ready (stg_ready[i]),
        .s_data  (stg_data[i]),
        .m_valid (stg_valid[i+1]),
        .m_ready (stg_ready[i+1]),
        .m_data  (stg_data[i+1])
      );
    end

    assign s_tready = rst ? RST_RDY : ((state_q == ST_DROP) || stg_ready[0]);
    assign m_tvalid = stg_valid[PL_DEPTH];
    assign {m_tuser, m_tlast, m_tkeep, m_tdata} = stg_data[PL_DEPTH];

    assign s_acc = s_tvalid && s_tready;
    assign m_acc = m_tvalid && m_tready;

    always_comb begin
      state_d       = state_q;
      occ_d         = occ_q;
      pkt_cnt_d     = pkt_cnt_q;
      in_pkt_d      = in_pkt_q;
      out_pkt_d     = out_pkt_q;
      flush_trunc_d = 1'b0;
      drop_inc      = '0;
      if (s_acc) in_pkt_d  = !s_tlast;
      if (m_acc) out_pkt_d = !m_tlast;
      if (state_q == ST_DROP) begin
        drop_inc = IW'(s_acc);
        if (s_acc && s_tlast) state_d = ST_PASS;
      end else if (flush) begin
        occ_d     = '0;
        pkt_cnt_d = '0;
        out_pkt_d = 1'b0;
        // A beat leaving the source this cycle is delivered, so it decides
        // whether the consumer was left holding a partial packet.
        flush_trunc_d = m_acc ? !m_tlast : out_pkt_q;
        // Discarded = held beats not delivered now + any sink beat now.
        drop_inc = {1'b0, occ_q} - IW'(m_acc) + IW'(s_acc);
        if (s_acc ? !s_tlast : in_pkt_q) state_d = ST_DROP;
      end else begin
        occ_d     = occ_q + OCC_W'(s_acc) - OCC_W'(m_acc);
        pkt_cnt_d = pkt_cnt_q + OCC_W'(s_acc && s_tlast) - OCC_W'(m_acc && m_tlast);
      end
      drop_sum   = {1'b0, drop_cnt_q} + (CNT_W+1)'(drop_inc);
      drop_cnt_d = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q       <= ST_PASS;
        occ_q         <= '0;
        pkt_cnt_q     <= '0;
        in_pkt_q      <= 1'b0;
        out_pkt_q     <= 1'b0;
        flush_trunc_q <= 1'b0;
        drop_cnt_q    <= '0;
      end else begin
        state_q       <= state_d;
        occ_q         <= occ_d;
        pkt_cnt_q     <= pkt_cnt_d;
        in_pkt_q      <= in_pkt_d;
        out_pkt_q     <= out_pkt_d;
        flush_trunc_q <= flush_trunc_d;
        drop_cnt_q    <= drop_cnt_d;
      end
    end

    assign occ         = occ_q;
    assign pkt_cnt     = pkt_cnt_q;
    assign idle        = (occ_q == '0) && (state_q == ST_PASS);
    assign dropping    = (state_q == ST_DROP);
    assign flush_trunc = flush_trunc_q;
    assign drop_cnt    = drop_cnt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_ofs_fim_axis_pipeline_flush.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ofs_fim_axis_pipeline_flush                                |
// | Purpose  : Self-checking bench: skid pipe (MODE 0, depth 3) driven with  |
// |            a scoreboard of expected beats, plus a bubble pipe (MODE 2,   |
// |            depth 1) for the half-rate acceptance pattern.                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ofs_fim_axis_pipeline_flush;

  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int UW = 10;
  localparam int PW = DW + KW + 1 + UW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // skid DUT
  logic          s_tvalid, s_tready, s_tlast, m_tvalid, m_tready, m_tlast;
  logic [DW-1:0] s_tdata, m_tdata;
  logic [KW-1:0] s_tkeep, m_tkeep;
  logic [UW-1:0] s_tuser, m_tuser;
  logic          flush, idle, dropping, flush_trunc;
  logic [2:0]    occ, pkt_cnt;
  logic [15:0]   drop_cnt;

  // bubble DUT
  logic          b_s_tvalid, b_s_tready, b_m_tvalid, b_m_tready, b_m_tlast;
  logic [DW-1:0] b_s_tdata, b_m_tdata;
  logic [KW-1:0] b_m_tkeep;
  logic [UW-1:0] b_m_tuser;
  logic          b_idle, b_dropping, b_flush_trunc;
  logic [1:0]    b_occ, b_pkt_cnt;
  logic [15:0]   b_drop_cnt;

  ofs_fim_axis_pipeline_flush #(
    .MODE(0), .TREADY_RST_VAL(1), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .PL_DEPTH(3), .CNT_W(16)
  ) u_dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .m_tuser(m_tuser),
    .flush(flush), .occ(occ), .pkt_cnt(pkt_cnt), .idle(idle), .dropping(dropping),
    .flush_trunc(flush_trunc), .drop_cnt(drop_cnt)
  );

  ofs_fim_axis_pipeline_flush #(
    .MODE(2), .TREADY_RST_VAL(0), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .PL_DEPTH(1), .CNT_W(16)
  ) u_bub (
    .clk(clk), .rst(rst),
    .s_tvalid(b_s_tvalid), .s_tready(b_s_tready), .s_tdata(b_s_tdata), .s_tkeep({KW{1'b1}}),
    .s_tlast(1'b1), .s_tuser({UW{1'b0}}),
    .m_tvalid(b_m_tvalid), .m_tready(b_m_tready), .m_tdata(b_m_tdata), .m_tkeep(b_m_tkeep),
    .m_tlast(b_m_tlast), .m_tuser(b_m_tuser),
    .flush(1'b0), .occ(b_occ), .pkt_cnt(b_pkt_cnt), .idle(b_idle), .dropping(b_dropping),
    .flush_trunc(b_flush_trunc), .drop_cnt(b_drop_cnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [PW-1:0] sb[$];
  int out_count = 0, mark_outs = 0, first_out_cyc = 0, last_out_cyc = 0;
  int acc_cyc = 0, stalls = 0, first_acc = 0;

  function automatic logic [KW-1:0] kf(input logic [DW-1:0] d);
    return d[KW-1:0] ^ 4'hA;
  endfunction
  function automatic logic [UW-1:0] uf(input logic [DW-1:0] d);
    return d[UW-1:0] ^ 10'h155;
  endfunction
  function automatic logic [PW-1:0] pay(input logic [DW-1:0] d, input logic l);
    return {uf(d), l, kf(d), d};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Source-side scoreboard consumer for the skid DUT.
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      if (sb.size() == 0) begin
        check("out_with_empty_sb", 64'(sb.size()), 64'd1);
      end else begin
        logic [PW-1:0] e;
        e = sb.pop_front();
        check("out_payload", 64'({m_tuser, m_tlast, m_tkeep, m_tdata}), 64'(e));
      end
      if (out_count == mark_outs) first_out_cyc = cyc;
      last_out_cyc = cyc;
      out_count++;
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic l, input bit keep_it);
    int n;
    bit ok;
    n = 0;
    ok = 1'b1;
    s_tvalid = 1'b1; s_tdata = d; s_tkeep = kf(d); s_tuser = uf(d); s_tlast = l;
    @(negedge clk);
    while (!s_tready && ok) begin
      n++;
      stalls++;
      if (n > 100) begin
        check("sink_accept_timeout", 64'(n), 64'd0);
        ok = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    acc_cyc = cyc;
    if (ok && keep_it) sb.push_back(pay(d, l));
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("drain_sb_empty", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bacc, bnext;
    bit acc;
    s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tuser = '0;
    m_tready = 1'b1; flush = 1'b0;
    b_s_tvalid = 1'b0; b_s_tdata = '0; b_m_tready = 1'b1;

    // Reset held 5 clocks
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("rst_s_tready", 64'(s_tready), 64'd1);
      check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      check("rst_occ", 64'(occ), 64'd0);
    end
    check("rst_b_s_tready", 64'(b_s_tready), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_dropping", 64'(dropping), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_s_tready", 64'(s_tready), 64'd1);
    check("post_rst_idle", 64'(idle), 64'd1);

    // Throughput: 100 back-to-back beats, packets of 10
    stalls = 0;
    mark_outs = out_count;
    for (int i = 0; i < 100; i++) begin
      send_beat(32'h1000 + i, (i % 10) == 9, 1'b1);
      if (i == 0) first_acc = acc_cyc;
    end
    wait_drain(50);
    check("tput_stalls", 64'(stalls), 64'd0);
    check("tput_out_count", 64'(out_count - mark_outs), 64'd100);
    check("tput_latency", 64'(first_out_cyc - first_acc), 64'd3);
    check("tput_out_span", 64'(last_out_cyc - first_out_cyc), 64'd99);
    check("tput_occ", 64'(occ), 64'd0);
    check("tput_pkt_cnt", 64'(pkt_cnt), 64'd0);

    // Backpressure: 6 beats fill a 3-stage skid pipe
    m_tready = 1'b0;
    for (int i = 0; i < 6; i++) send_beat(32'h2000 + i, i == 5, 1'b1);
    check("bp_occ_full", 64'(occ), 64'd6);
    check("bp_s_tready", 64'(s_tready), 64'd0);
    check("bp_pkt_cnt", 64'(pkt_cnt), 64'd1);
    repeat (3) begin @(posedge clk); #1; end
    check("bp_occ_hold", 64'(occ), 64'd6);
    check("bp_m_tvalid_hold", 64'(m_tvalid), 64'd1);
    m_tready = 1'b1;
    wait_drain(20);
    check("bp_occ_drained", 64'(occ), 64'd0);
    check("bp_idle", 64'(idle), 64'd1);

    // Flush mid-packet: beats 1,2 delivered, beat 3 in flight, 4..8 dropped
    send_beat(32'h3000, 1'b0, 1'b1);
    send_beat(32'h3001, 1'b0, 1'b1);
    wait_drain(20);
    send_beat(32'h3002, 1'b0, 1'b1);
    check("fl_occ_before", 64'(occ), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    sb.delete();
    #1;
    flush = 1'b0;
    check("fl_trunc", 64'(flush_trunc), 64'd1);
    check("fl_dropping", 64'(dropping), 64'd1);
    check("fl_occ", 64'(occ), 64'd0);
    check("fl_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("fl_drop_cnt_pipe", 64'(drop_cnt), 64'd1);
    check("fl_m_tvalid", 64'(m_tvalid), 64'd0);
    @(posedge clk); #1;
    check("fl_trunc_pulse", 64'(flush_trunc), 64'd0);
    for (int i = 0; i < 5; i++) begin
      send_beat(32'h3003 + i, i == 4, 1'b0);
      if (i == 3) check("fl_dropping_mid", 64'(dropping), 64'd1);
    end
    check("fl_dropping_end", 64'(dropping), 64'd0);
    check("fl_drop_cnt", 64'(drop_cnt), 64'd6);
    for (int i = 0; i < 4; i++) send_beat(32'h3100 + i, i == 3, 1'b1);
    wait_drain(20);
    check("fl_next_pkt_drop_cnt", 64'(drop_cnt), 64'd6);

    // Flush with only complete packets held
    m_tready = 1'b0;
    send_beat(32'h4000, 1'b0, 1'b1);
    send_beat(32'h4001, 1'b1, 1'b1);
    send_beat(32'h4002, 1'b1, 1'b1);
    check("cp_pkt_cnt", 64'(pkt_cnt), 64'd2);
    check("cp_occ", 64'(occ), 64'd3);
    flush = 1'b1;
    @(posedge clk);
    sb.delete();
    #1;
    flush = 1'b0;
    check("cp_trunc", 64'(flush_trunc), 64'd0);
    check("cp_dropping", 64'(dropping), 64'd0);
    check("cp_occ_after", 64'(occ), 64'd0);
    check("cp_pkt_cnt_after", 64'(pkt_cnt), 64'd0);
    check("cp_drop_cnt", 64'(drop_cnt), 64'd9);
    m_tready = 1'b1;
    send_beat(32'h4100, 1'b1, 1'b1);
    wait_drain(20);
    check("cp_occ_final", 64'(occ), 64'd0);

    // Bubble pipe: continuous input, one accept every two clocks
    bacc = 0;
    bnext = 0;
    b_s_tvalid = 1'b1;
    b_s_tdata = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b_m_tvalid && b_m_tready) begin
        check("bubble_order", 64'(b_m_tdata), 64'(bnext));
        bnext++;
      end
      acc = b_s_tvalid && b_s_tready;
      if (acc) bacc++;
      @(posedge clk); #1;
      if (acc) b_s_tdata = b_s_tdata + 1;
    end
    b_s_tvalid = 1'b0;
    check("bubble_accepts", 64'(bacc), 64'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
